// File: rtl/eth_rst_pkg.sv
// Shared definitions for the Ethernet reset sequencer: state encoding
// and default cycle constants for a 25 MHz sequencer clock.
package eth_rst_pkg;

  // State encoding is visible on state_o, so the values are fixed.
  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_PHY_RST   = 3'd1,
    ST_PHY_WAIT  = 3'd2,
    ST_MAC_WAIT  = 3'd3,
    ST_RUN       = 3'd4
  } state_t;

  // Defaults for 25 MHz: 10 ms PHY reset pulse, 5 ms PHY settle time.
  localparam int unsigned DEF_LOCK_FILTER      = 8;
  localparam int unsigned DEF_PHY_RST_CYCLES   = 250000;
  localparam int unsigned DEF_PHY_WAIT_CYCLES  = 125000;
  localparam int unsigned DEF_MAC_DELAY_CYCLES = 16;
  localparam int unsigned DEF_CNT_W            = 18;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous level.
// Resets to 0 so a lock that was present before reset is re-qualified.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops give the first stage a full cycle to resolve.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make both flops sample the old
      // value on the same edge; blocking here would collapse the chain.
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/eth_rst_seq.sv
// Power-up / recovery reset sequencer: qualifies PLL lock, then releases
// the PHY reset pin, the MAC reset and the user reset in order. Any lock
// loss or software restart request re-runs the sequence.
module eth_rst_seq
  import eth_rst_pkg::*;
#(
  parameter int unsigned LOCK_FILTER      = DEF_LOCK_FILTER,
  parameter int unsigned PHY_RST_CYCLES   = DEF_PHY_RST_CYCLES,
  parameter int unsigned PHY_WAIT_CYCLES  = DEF_PHY_WAIT_CYCLES,
  parameter int unsigned MAC_DELAY_CYCLES = DEF_MAC_DELAY_CYCLES,
  parameter int unsigned CNT_W            = DEF_CNT_W
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       pll_locked_i,
  input  logic       soft_rst_i,
  output logic       phy_rst_no,
  output logic       mac_rst_o,
  output logic       usr_rst_o,
  output logic       ready_o,
  output logic [2:0] state_o,
  output logic [7:0] restart_cnt_o
);

  localparam int unsigned FILT_W = $clog2(LOCK_FILTER + 1);

  // Timers count down from N-1 to 0 so a timed state lasts exactly N cycles.
  localparam logic [CNT_W-1:0]  LD_PHY_RST  = CNT_W'(PHY_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  LD_PHY_WAIT = CNT_W'(PHY_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  LD_MAC_WAIT = CNT_W'(MAC_DELAY_CYCLES - 1);
  localparam logic [FILT_W-1:0] FILT_LAST   = FILT_W'(LOCK_FILTER - 1);

  logic              lock_s;
  state_t            state, state_nxt;
  logic [CNT_W-1:0]  timer, timer_nxt;
  logic [FILT_W-1:0] filt_cnt, filt_nxt;
  logic              timer_zero;
  logic              restart_inc;
  logic              phy_rst_n_nxt, mac_rst_nxt, usr_rst_nxt, ready_nxt;

  sync_2ff u_lock_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d     (pll_locked_i),
    .q     (lock_s)
  );

  assign timer_zero = (timer == '0);

  // Next-state, timer and lock-filter logic; lock loss always takes priority.
  always_comb begin
    // NOTE: every variable gets a default before the case, so no path
    // leaves one unassigned and no latch is inferred.
    state_nxt = state;
    timer_nxt = timer;
    filt_nxt  = '0;

    unique case (state)
      ST_WAIT_LOCK: begin
        timer_nxt = '0;
        if (lock_s) begin
          if (filt_cnt == FILT_LAST) begin
            state_nxt = ST_PHY_RST;
            timer_nxt = LD_PHY_RST;
          end else begin
            filt_nxt = filt_cnt + 1'b1;
          end
        end
      end

      ST_PHY_RST: begin
        if (!lock_s) begin
          state_nxt = ST_WAIT_LOCK;
          timer_nxt = '0;
        end else if (soft_rst_i) begin
          // Restart request while the pin is already low stretches the pulse.
          timer_nxt = LD_PHY_RST;
        end else if (timer_zero) begin
          state_nxt = ST_PHY_WAIT;
          timer_nxt = LD_PHY_WAIT;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end

      ST_PHY_WAIT: begin
        if (!lock_s) begin
          state_nxt = ST_WAIT_LOCK;
          timer_nxt = '0;
        end else if (soft_rst_i) begin
          state_nxt = ST_PHY_RST;
          timer_nxt = LD_PHY_RST;
        end else if (timer_zero) begin
          state_nxt = ST_MAC_WAIT;
          timer_nxt = LD_MAC_WAIT;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end

      ST_MAC_WAIT: begin
        if (!lock_s) begin
          state_nxt = ST_WAIT_LOCK;
          timer_nxt = '0;
        end else if (soft_rst_i) begin
          state_nxt = ST_PHY_RST;
          timer_nxt = LD_PHY_RST;
        end else if (timer_zero) begin
          state_nxt = ST_RUN;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end

      ST_RUN: begin
        if (!lock_s) begin
          state_nxt = ST_WAIT_LOCK;
          timer_nxt = '0;
        end else if (soft_rst_i) begin
          state_nxt = ST_PHY_RST;
          timer_nxt = LD_PHY_RST;
        end
      end

      default: begin
        state_nxt = ST_WAIT_LOCK;
        timer_nxt = '0;
      end
    endcase
  end

  // Output values are decoded from the next state so they change on the
  // same edge that registers the state, keeping every output a flop.
  always_comb begin
    phy_rst_n_nxt = (state_nxt == ST_PHY_WAIT) || (state_nxt == ST_MAC_WAIT) ||
                    (state_nxt == ST_RUN);
    mac_rst_nxt   = (state_nxt == ST_WAIT_LOCK) || (state_nxt == ST_PHY_RST) ||
                    (state_nxt == ST_PHY_WAIT);
    usr_rst_nxt   = (state_nxt != ST_RUN);
    ready_nxt     = (state_nxt == ST_RUN);
    restart_inc   = (state == ST_RUN) && (state_nxt != ST_RUN);
  end

  // State, timer, filter and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= ST_WAIT_LOCK;
      timer      <= '0;
      filt_cnt   <= '0;
      phy_rst_no <= 1'b0;
      mac_rst_o  <= 1'b1;
      usr_rst_o  <= 1'b1;
      ready_o    <= 1'b0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      filt_cnt   <= filt_nxt;
      phy_rst_no <= phy_rst_n_nxt;
      mac_rst_o  <= mac_rst_nxt;
      usr_rst_o  <= usr_rst_nxt;
      ready_o    <= ready_nxt;
    end
  end

  // Restart counter: counts exits from RUN, holds at 255.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      restart_cnt_o <= 8'd0;
    end else if (restart_inc && (restart_cnt_o != 8'hFF)) begin
      restart_cnt_o <= restart_cnt_o + 8'd1;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_eth_rst_seq.sv
// Directed bench for eth_rst_seq with short timer values.
module tb_eth_rst_seq;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       pll_locked_i;
  logic       soft_rst_i;
  logic       phy_rst_no;
  logic       mac_rst_o;
  logic       usr_rst_o;
  logic       ready_o;
  logic [2:0] state_o;
  logic [7:0] restart_cnt_o;

  int checks = 0;
  int errors = 0;
  int inv_viol = 0;

  eth_rst_seq #(
    .LOCK_FILTER     (3),
    .PHY_RST_CYCLES  (10),
    .PHY_WAIT_CYCLES (6),
    .MAC_DELAY_CYCLES(4),
    .CNT_W           (4)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .pll_locked_i (pll_locked_i),
    .soft_rst_i   (soft_rst_i),
    .phy_rst_no   (phy_rst_no),
    .mac_rst_o    (mac_rst_o),
    .usr_rst_o    (usr_rst_o),
    .ready_o      (ready_o),
    .state_o      (state_o),
    .restart_cnt_o(restart_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected outputs per state, from the state/output table.
  function automatic logic [14:0] exp_v(input logic [2:0] st, input logic [7:0] cnt);
    logic phy, mac, usr, rdy;
    phy = (st == 3'd2) || (st == 3'd3) || (st == 3'd4);
    mac = (st == 3'd0) || (st == 3'd1) || (st == 3'd2);
    usr = (st != 3'd4);
    rdy = (st == 3'd4);
    return {st, phy, mac, usr, rdy, cnt};
  endfunction

  task automatic expect_st(input string tag, input logic [2:0] st, input logic [7:0] cnt);
    check(tag, 32'({state_o, phy_rst_no, mac_rst_o, usr_rst_o, ready_o, restart_cnt_o}),
          32'(exp_v(st, cnt)));
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic soft_pulse();
    soft_rst_i = 1'b1;
    step(1);
    soft_rst_i = 1'b0;
  endtask

  // Ordering invariant: mac never out of reset while PHY is, usr never before mac.
  always @(negedge clk) begin
    if (rst_ni === 1'b1) begin
      if ((mac_rst_o == 1'b0 && phy_rst_no == 1'b0) ||
          (usr_rst_o == 1'b0 && mac_rst_o == 1'b1))
        inv_viol++;
    end
  end

  initial begin
    rst_ni       = 1'b0;
    pll_locked_i = 1'b0;
    soft_rst_i   = 1'b0;
    step(2);
    expect_st("reset_values", 3'd0, 8'd0);

    rst_ni = 1'b1;
    step(3);
    expect_st("no_lock_idle", 3'd0, 8'd0);

    // 1: clean power-up sequence.
    pll_locked_i = 1'b1;
    step(4);
    expect_st("lock_filter_wait", 3'd0, 8'd0);
    step(1);
    expect_st("phy_rst_entry", 3'd1, 8'd0);
    step(9);
    expect_st("phy_rst_last", 3'd1, 8'd0);
    step(1);
    expect_st("phy_wait_entry", 3'd2, 8'd0);
    step(5);
    expect_st("phy_wait_last", 3'd2, 8'd0);
    step(1);
    expect_st("mac_wait_entry", 3'd3, 8'd0);
    step(3);
    expect_st("mac_wait_last", 3'd3, 8'd0);
    step(1);
    expect_st("run_entry", 3'd4, 8'd0);

    // 3: lock loss in RUN.
    pll_locked_i = 1'b0;
    step(2);
    expect_st("lock_loss_sync", 3'd4, 8'd0);
    step(1);
    expect_st("lock_loss_exit", 3'd0, 8'd1);

    // 2: one-cycle lock glitch while filtering delays PHY_RST by three cycles.
    pll_locked_i = 1'b1;
    step(2);
    pll_locked_i = 1'b0;
    step(1);
    pll_locked_i = 1'b1;
    step(4);
    expect_st("glitch_filter_restart", 3'd0, 8'd1);
    step(1);
    expect_st("glitch_phy_rst_entry", 3'd1, 8'd1);
    step(20);
    expect_st("resequence_run", 3'd4, 8'd1);

    // 4: soft reset pulse in RUN.
    soft_pulse();
    expect_st("soft_run_exit", 3'd1, 8'd2);
    step(9);
    expect_st("soft_phy_rst_last", 3'd1, 8'd2);
    step(1);
    expect_st("soft_phy_wait", 3'd2, 8'd2);
    step(6);
    expect_st("soft_mac_wait", 3'd3, 8'd2);
    soft_pulse();
    expect_st("soft_in_mac_wait", 3'd1, 8'd2);
    // Pulse mid-PHY_RST reloads the timer and stretches the pulse.
    step(4);
    soft_pulse();
    expect_st("soft_in_phy_rst", 3'd1, 8'd2);
    step(9);
    expect_st("stretched_phy_rst", 3'd1, 8'd2);
    step(1);
    expect_st("stretched_release", 3'd2, 8'd2);
    step(10);
    expect_st("soft_back_to_run", 3'd4, 8'd2);

    // 5: lock loss and soft reset on the same FSM cycle: lock loss wins.
    pll_locked_i = 1'b0;
    step(2);
    soft_pulse();
    expect_st("lock_beats_soft", 3'd0, 8'd3);
    pll_locked_i = 1'b1;
    step(5);
    expect_st("relock_phy_rst", 3'd1, 8'd3);

    for (int i = 0; i < 300; i++) begin
      step(20);
      soft_pulse();
      if (i == 250) expect_st("restart_cnt_254", 3'd1, 8'd254);
    end
    expect_st("restart_cnt_sat", 3'd1, 8'd255);

    // 6: asynchronous reset in the middle of PHY_WAIT.
    step(10);
    expect_st("pre_async_phy_wait", 3'd2, 8'd255);
    step(2);
    #2 rst_ni = 1'b0;
    #1 expect_st("async_reset_now", 3'd0, 8'd0);
    step(1);
    rst_ni = 1'b1;
    step(4);
    expect_st("post_reset_filter", 3'd0, 8'd0);
    step(1);
    expect_st("post_reset_phy_rst", 3'd1, 8'd0);

    check("sequence_order", 32'(inv_viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
